// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory-port arbiter: state encoding,
// read/write direction constants and default bus widths.
package mem_arb_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector. A lone requester always wins; on a tie the
// master that is not the current owner wins. Purely combinational so it can
// be shared with other arbiters (e.g. the interrupt controller).
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       owner,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Pick the winner from the request pair and the last owner.
  always_comb begin
    grant_valid = |req;
    if (req == 2'b11) begin
      grant_idx = ~owner;
    end else begin
      grant_idx = req[1];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between the cpu (master 0) and the I/O DMA engine
// (master 1) for the single memory port. Sequences the memory's four-phase
// en/ack handshake and returns a one-cycle ack plus read data to the winner.
// All outputs are registered.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort an access that sees no
// mem_ack within TIMEOUT cycles; this adds the TIMEOUT parameter and the err
// output port.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_rdwr,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_rdwr,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_rdwr,
  output logic          mem_en,
  input  logic          mem_ack,
  output logic          owner
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic          err
`endif
);

  state_t state, next_state;

  logic grant_valid;
  logic grant_idx;
  logic grant;      // arbitration won this cycle, access starts at next edge
  logic done;       // access finishes this cycle (ack or timeout)
  logic timeout;

  // Next-cycle values of the registered outputs.
  logic          mem_en_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic          mem_rdwr_d;
  logic          owner_d;
  logic          m0_ack_d;
  logic          m1_ack_d;
  logic [DW-1:0] m0_rdata_d;
  logic [DW-1:0] m1_rdata_d;

  rr_pick2 u_pick (
    .req         ({m1_req, m0_req}),
    .owner       (owner),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // A stray mem_ack in IDLE blocks arbitration until memory is quiet again.
  assign grant = (state == ST_IDLE) && grant_valid && !mem_ack;
  assign done  = (state == ST_ACCESS) && (mem_ack || timeout);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic          err_d;

  // Count ACCESS cycles; held at zero elsewhere so every access starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ST_ACCESS) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign timeout = (state == ST_ACCESS) && !mem_ack && (cnt == TO_LAST);
  assign err_d   = timeout;
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so flop-to-flop order inside a block never matters.
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic for the en/ack handshake.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch forms.
    next_state = state;
    case (state)
      ST_IDLE:    if (grant)    next_state = ST_ACCESS;
      ST_ACCESS:  if (done)     next_state = ST_RELEASE;
      ST_RELEASE: if (!mem_ack) next_state = ST_IDLE;
      default:                  next_state = ST_IDLE;
    endcase
  end

  // Output decode: next values of the memory-side and master-side registers.
  always_comb begin
    mem_en_d    = mem_en;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_rdwr_d  = mem_rdwr;
    owner_d     = owner;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_rdata_d  = m0_rdata;
    m1_rdata_d  = m1_rdata;

    if (grant) begin
      owner_d  = grant_idx;
      mem_en_d = 1'b1;
      if (grant_idx) begin
        mem_addr_d  = m1_addr;
        mem_wdata_d = m1_wdata;
        mem_rdwr_d  = m1_rdwr;
      end else begin
        mem_addr_d  = m0_addr;
        mem_wdata_d = m0_wdata;
        mem_rdwr_d  = m0_rdwr;
      end
    end

    if (done) begin
      mem_en_d = 1'b0;
      m0_ack_d = ~owner;
      m1_ack_d = owner;
      // A timed-out read leaves the previous read data in place.
      if (mem_ack && (mem_rdwr == RD)) begin
        if (owner) begin
          m1_rdata_d = mem_rdata;
        end else begin
          m0_rdata_d = mem_rdata;
        end
      end
    end
  end

  // Output registers; reset drops mem_en immediately and suppresses any ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rdwr  <= RD;
      owner     <= 1'b1;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err       <= 1'b0;
`endif
    end else begin
      mem_en    <= mem_en_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_rdwr  <= mem_rdwr_d;
      owner     <= owner_d;
      m0_ack    <= m0_ack_d;
      m1_ack    <= m1_ack_d;
      m0_rdata  <= m0_rdata_d;
      m1_rdata  <= m1_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      err       <= err_d;
`endif
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter for the single 12-bit-address / 16-bit-data memory port.
- Master 0 is the cpu; master 1 is an I/O DMA engine moving keyboard/display data.
- Grants round-robin and sequences the memory's four-phase en/ack handshake.
- Returns read data and a one-cycle completion pulse to the winning master; the top level owns the inout data tristate.

Parameters:
- AW, 12, address width.
- DW, 16, data width.
- TIMEOUT, 64, cycles waited for mem_ack before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req / m1_req  in  1  master access request, held until its ack.
- m0_addr / m1_addr  in  AW  address, stable while req high.
- m0_wdata / m1_wdata  in  DW  write data.
- m0_rdwr / m1_rdwr  in  1  1 = read, 0 = write.
- m0_ack / m1_ack  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  DW  read data, valid from the ack cycle until that master's next completion.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- mem_rdwr  out  1  memory direction, same encoding as the master rdwr.
- mem_en  out  1  memory enable.
- mem_ack  in  1  memory acknowledge.
- owner  out  1  index of the granted / last-granted master.

Behaviour:
- Reset (async, active-high): state IDLE; mem_en, m0_ack, m1_ack = 0; mem_addr, mem_wdata = 0; mem_rdwr = 1; m0_rdata, m1_rdata = 0; owner = 1, so master 0 wins the first tie.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RELEASE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both requesting: grant the master that is not owner (round-robin).
  - On grant, at the next edge: latch that master's addr/wdata/rdwr onto the mem_* outputs, set owner, mem_en = 1, go to ACCESS.
- ACCESS:
  - Hold mem_* stable.
  - mem_ack sampled 1: at the next edge mem_en = 0, m<owner>_ack = 1 for one cycle, capture mem_rdata into m<owner>_rdata (read only), go to RELEASE.
- RELEASE:
  - Hold mem_en = 0 until mem_ack is sampled 0, then go to IDLE.
  - No new grant is issued while mem_ack is high.
- Latency: req seen in IDLE at cycle n gives mem_en at n+1. With a combinational ack, ack at n+1 gives master ack at n+2. Minimum back-to-back spacing is 3 cycles.
- Master rules:
  - Requester drops req in the cycle after its ack.
  - A req still high one cycle after ack is a new request.
  - Changing addr/rdwr while req is high before ack is illegal; the values latched at grant are used.
- A request from the non-owner arriving during ACCESS/RELEASE waits; it wins the next IDLE arbitration.
- mem_ack high while in IDLE (protocol error): ignored, no grant until mem_ack is low.
- Reset mid-operation: mem_en drops asynchronously and no ack pulse is issued; the master must re-request.
- m0_ack and m1_ack are never high together.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to ACCESS and increments each ACCESS cycle.
  - When it reaches TIMEOUT-1 without mem_ack: mem_en = 0, m<owner>_ack pulses with rdata unchanged, an extra output port err pulses for one cycle, and the FSM goes to RELEASE.
  - err resets to 0.
- Not defined: no counter, no err port; ACCESS waits indefinitely.

Decomposition:
- Package mem_arb_pkg:
  - state encoding constants ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RELEASE = 2'd2.
  - RD = 1'b1 and WR = 1'b0 constants.
  - default AW/DW.
- One natural sub-module, rr_pick2: the combinational round-robin selector (inputs req[1:0] and owner; outputs grant_valid and grant_idx). It is reused by the planned interrupt controller.

Test Plan:
- Single read: m0 reads addr 12'h0A5, memory returns 16'h1234 with 1-cycle ack -> mem_en high 1 cycle after req; m0_ack pulse; m0_rdata = 16'h1234; m1_ack never rises.
- Write: m1 writes 16'hBEEF to 12'h7FF -> mem_addr = 7FF, mem_wdata = BEEF, mem_rdwr = 0 while mem_en is high; m1_ack after mem_ack.
- Contention: both req continuously, 6 accesses -> grant order 0,1,0,1,0,1 and owner toggles; never two acks in one cycle.
- Slow memory: mem_ack delayed 10 cycles and held high 3 cycles after mem_en drops -> mem_* stable through ACCESS; no new mem_en until mem_ack is low; pending m1 is then granted.
- Reset mid-access: assert rst 2 cycles into ACCESS -> mem_en = 0 immediately, no ack pulse, owner = 1; after release, m0 wins a tie.
- MEM_ARB_TIMEOUT_EN with TIMEOUT = 8 and mem_ack never asserted -> after 8 ACCESS cycles mem_en = 0, err and m0_ack pulse together, FSM returns to IDLE.
